wishbone_arbiter: RTL

- Multi-master Wishbone B4 classic-cycle arbiter. It sits directly downstream of the core's Wishbone masters: the load/store Wishbone master and the instruction-fetch master.
- It multiplexes them onto a single shared slave port.
- Grant is held for as long as the owning master holds cyc. This keeps LR/SC and AMO read-modify-write sequences atomic on the bus.
- A bus watchdog terminates stalled transfers with err.

---
 rtl/wishbone_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: N masters onto one slave port, ownership held
// while the owner keeps cyc asserted, with a watchdog that aborts stalled strobes with err.
module wishbone_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS-1:0][31:0]  m_adr,
    input  logic [NUM_MASTERS-1:0][3:0]   m_sel,
    input  logic [NUM_MASTERS-1:0][31:0]  m_dat_w,
    input  logic [NUM_MASTERS-1:0][2:0]   m_cti,
    input  logic [NUM_MASTERS-1:0][1:0]   m_bte,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [31:0]                   m_dat_r,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [31:0]                   s_adr,
    output logic [3:0]                    s_sel,
    output logic [31:0]                   s_dat_w,
    output logic [2:0]                    s_cti,
    output logic [1:0]                    s_bte,
    input  logic                          s_ack,
    input  logic                          s_err,
    input  logic [31:0]                   s_dat_r,
    output logic [NUM_MASTERS-1:0]        grant
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W:0]   NM      = (IDX_W + 1)'(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, GRANTED, ABORT} state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [IDX_W-1:0]       gidx, gidx_nxt;
    logic [IDX_W-1:0]       last_grant, last_grant_nxt;
    logic [WD_W-1:0]        wd, wd_nxt;
    logic                   req_found;
    logic [IDX_W-1:0]       req_idx;
    logic [IDX_W:0]         cand;

    // Round-robin search starting just above the previous owner.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = {1'b0, last_grant} + (IDX_W + 1)'(i);
            if (cand >= NM)
                cand = cand - NM;
            if (!req_found && m_cyc[cand[IDX_W-1:0]]) begin
                req_found = 1'b1;
                req_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        gidx_nxt       = gidx;
        last_grant_nxt = last_grant;
        wd_nxt         = '0;
        case (state)
            IDLE: begin
                if (req_found) begin
                    state_nxt      = GRANTED;
                    gidx_nxt       = req_idx;
                    last_grant_nxt = req_idx;
                    grant_nxt      = '0;
                    grant_nxt[req_idx] = 1'b1;
                end
            end
            GRANTED: begin
                if (!m_cyc[gidx]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (TIMEOUT > 0 && m_stb[gidx] && !s_ack && !s_err) begin
                    if (wd == WD_LAST)
                        state_nxt = ABORT;
                    else
                        wd_nxt = wd + 1'b1;
                end
            end
            ABORT: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            gidx       <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            wd         <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            gidx       <= gidx_nxt;
            last_grant <= last_grant_nxt;
            wd         <= wd_nxt;
        end
    end

    // Slave port mirrors the owner; only cyc/stb are qualified by state.
    always_comb begin
        s_cyc   = (state == GRANTED) && m_cyc[gidx];
        s_stb   = (state == GRANTED) && m_stb[gidx];
        s_we    = m_we[gidx];
        s_adr   = m_adr[gidx];
        s_sel   = m_sel[gidx];
        s_dat_w = m_dat_w[gidx];
        s_cti   = m_cti[gidx];
        s_bte   = m_bte[gidx];
    end

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (state == GRANTED) begin
            m_ack[gidx] = s_ack;
            m_err[gidx] = s_err;
        end else if (state == ABORT) begin
            m_err[gidx] = 1'b1;
        end
    end

    assign m_dat_r = s_dat_r;

endmodule
